// File: rtl/lab_stats_accum.sv
// Per-channel mean/variance accumulator for a frame of lab pixels (Q3.13 in,
// Q3.13 mean and Q6.26 variance out), feeding the colour-transfer scale stage.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; last statistics held on the outputs
// S_ACCUM | o_ready=1, accepting pixels into the 1-stage pipe
// S_DRAIN | last registered pixel folded into the accumulators
// S_CALC  | one channel per cycle (l, a, b): mean and variance
// S_DONE  | o_stat_valid=1 until i_stat_ack
module lab_stats_accum #(
    parameter int LOG2_NPIX = 16,
    parameter int W         = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic signed [W-1:0] i_l,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic                o_busy,
    output logic                o_stat_valid,
    input  logic                i_stat_ack,
    output logic signed [W-1:0] o_mean_l,
    output logic signed [W-1:0] o_mean_a,
    output logic signed [W-1:0] o_mean_b,
    output logic [31:0]         o_var_l,
    output logic [31:0]         o_var_a,
    output logic [31:0]         o_var_b
);

    localparam int SW = W + LOG2_NPIX;
    localparam int QW = 2*W - 1 + LOG2_NPIX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_CALC,
        S_DONE
    } state_t;

    state_t                state;
    logic [LOG2_NPIX-1:0]  pix_cnt;
    logic [1:0]            ch;

    logic                  pix_vld;
    logic signed [W-1:0]   pix_l;
    logic signed [W-1:0]   pix_a;
    logic signed [W-1:0]   pix_b;

    logic signed [SW-1:0]  sum_l;
    logic signed [SW-1:0]  sum_a;
    logic signed [SW-1:0]  sum_b;
    logic [QW-1:0]         sumsq_l;
    logic [QW-1:0]         sumsq_a;
    logic [QW-1:0]         sumsq_b;

    logic signed [2*W-1:0] sq_l;
    logic signed [2*W-1:0] sq_a;
    logic signed [2*W-1:0] sq_b;

    logic signed [SW-1:0]  sum_sel;
    logic [QW-1:0]         sumsq_sel;
    logic signed [W-1:0]   mean_c;
    logic signed [2*W-1:0] msq;
    logic [2*W-2:0]        ex2;
    logic signed [2*W:0]   diff;
    logic [31:0]           var_c;

    always_comb begin
        sq_l = pix_l * pix_l;
        sq_a = pix_a * pix_a;
        sq_b = pix_b * pix_b;
    end

    // Shared datapath for the three CALC cycles; ch picks the channel.
    always_comb begin
        sum_sel   = sum_l;
        sumsq_sel = sumsq_l;
        case (ch)
            2'd1: begin
                sum_sel   = sum_a;
                sumsq_sel = sumsq_a;
            end
            2'd2: begin
                sum_sel   = sum_b;
                sumsq_sel = sumsq_b;
            end
            default: begin
                sum_sel   = sum_l;
                sumsq_sel = sumsq_l;
            end
        endcase
        mean_c = W'(sum_sel >>> LOG2_NPIX);
        msq    = mean_c * mean_c;
        ex2    = (2*W-1)'(sumsq_sel >> LOG2_NPIX);
        diff   = $signed({2'b00, ex2}) - $signed({msq[2*W-1], msq});
        // Floor on the mean can push E[x^2]-mean^2 slightly below zero.
        var_c  = diff[2*W] ? 32'd0 : diff[31:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            ch           <= '0;
            pix_vld      <= 1'b0;
            pix_l        <= '0;
            pix_a        <= '0;
            pix_b        <= '0;
            sum_l        <= '0;
            sum_a        <= '0;
            sum_b        <= '0;
            sumsq_l      <= '0;
            sumsq_a      <= '0;
            sumsq_b      <= '0;
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_stat_valid <= 1'b0;
            o_mean_l     <= '0;
            o_mean_a     <= '0;
            o_mean_b     <= '0;
            o_var_l      <= '0;
            o_var_a      <= '0;
            o_var_b      <= '0;
        end else begin
            if (pix_vld) begin
                sum_l   <= sum_l + SW'(pix_l);
                sum_a   <= sum_a + SW'(pix_a);
                sum_b   <= sum_b + SW'(pix_b);
                sumsq_l <= sumsq_l + QW'($unsigned(sq_l));
                sumsq_a <= sumsq_a + QW'($unsigned(sq_a));
                sumsq_b <= sumsq_b + QW'($unsigned(sq_b));
            end

            case (state)
                S_IDLE: begin
                    o_stat_valid <= 1'b0;
                    if (i_start) begin
                        state   <= S_ACCUM;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                        pix_cnt <= '0;
                        pix_vld <= 1'b0;
                        sum_l   <= '0;
                        sum_a   <= '0;
                        sum_b   <= '0;
                        sumsq_l <= '0;
                        sumsq_a <= '0;
                        sumsq_b <= '0;
                    end
                end
                S_ACCUM: begin
                    pix_vld <= i_valid;
                    if (i_valid) begin
                        pix_l   <= i_l;
                        pix_a   <= i_a;
                        pix_b   <= i_b;
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == '1) begin
                            state   <= S_DRAIN;
                            o_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    pix_vld <= 1'b0;
                    ch      <= 2'd0;
                    state   <= S_CALC;
                end
                S_CALC: begin
                    case (ch)
                        2'd0: begin
                            o_mean_l <= mean_c;
                            o_var_l  <= var_c;
                        end
                        2'd1: begin
                            o_mean_a <= mean_c;
                            o_var_a  <= var_c;
                        end
                        default: begin
                            o_mean_b <= mean_c;
                            o_var_b  <= var_c;
                        end
                    endcase
                    ch <= ch + 2'd1;
                    if (ch == 2'd2) begin
                        state        <= S_DONE;
                        o_stat_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_stat_ack) begin
                        state        <= S_IDLE;
                        o_stat_valid <= 1'b0;
                        o_busy       <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab_stats_accum.sv
// Directed bench for lab_stats_accum: a 4-pixel frame instance for most
// scenarios plus a full 65536-pixel instance for the extreme-value frame.
module tb_lab_stats_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, valid, ack;
    logic [15:0] l, a, b;
    logic        ready, busy, sv;
    logic [15:0] mean_l, mean_a, mean_b;
    logic [31:0] var_l, var_a, var_b;

    logic        start16, valid16, ack16;
    logic [15:0] p16;
    logic        ready16, busy16, sv16;
    logic [15:0] mean_l16, mean_a16, mean_b16;
    logic [31:0] var_l16, var_a16, var_b16;

    int checks = 0;
    int errors = 0;

    lab_stats_accum #(.LOG2_NPIX(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .o_ready(ready), .i_l(l), .i_a(a), .i_b(b),
        .o_busy(busy), .o_stat_valid(sv), .i_stat_ack(ack),
        .o_mean_l(mean_l), .o_mean_a(mean_a), .o_mean_b(mean_b),
        .o_var_l(var_l), .o_var_a(var_a), .o_var_b(var_b)
    );

    lab_stats_accum #(.LOG2_NPIX(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_valid(valid16),
        .o_ready(ready16), .i_l(p16), .i_a(p16), .i_b(p16),
        .o_busy(busy16), .o_stat_valid(sv16), .i_stat_ack(ack16),
        .o_mean_l(mean_l16), .o_mean_a(mean_a16), .o_mean_b(mean_b16),
        .o_var_l(var_l16), .o_var_a(var_a16), .o_var_b(var_b16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Four back-to-back beats; item k of each vector is bits [16k+15:16k].
    task automatic send4(input logic [63:0] lv, input logic [63:0] av, input logic [63:0] bv);
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            l = lv[16*k +: 16];
            a = av[16*k +: 16];
            b = bv[16*k +: 16];
            step();
        end
        valid = 1'b0;
    endtask

    task automatic wait_stat();
        int n;
        n = 0;
        while (!sv && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sv !== 1'b1) begin
            errors++;
            $display("FAIL stat_timeout: o_stat_valid=%b want 1", sv);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({ready, busy, sv} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/valid=%b want 000", {ready, busy, sv});
        end
        checks++;
        if ({mean_l, mean_a, mean_b, var_l, var_a, var_b} !== '0) begin
            errors++;
            $display("FAIL reset_stats: %h %h %h %h %h %h want 0", mean_l, mean_a, mean_b, var_l, var_a, var_b);
        end
        checks++;
        if ({ready16, busy16, sv16, mean_l16, var_l16} !== '0) begin
            errors++;
            $display("FAIL reset_dut16: r=%b b=%b v=%b m=%h v=%h want 0", ready16, busy16, sv16, mean_l16, var_l16);
        end
    endtask

    task automatic test_constant();
        start_frame();
        checks++;
        if ({ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL t1_accum: ready/busy=%b want 11", {ready, busy});
        end
        send4({4{16'h2000}}, 64'h0, 64'h0);
        for (int c = 1; c <= 4; c++) begin
            if (c < 4) step();
            else step();
            checks++;
            if (sv !== (c == 4)) begin
                errors++;
                $display("FAIL t1_latency: cycle %0d after drain o_stat_valid=%b want %b", c, sv, (c == 4));
            end
        end
        checks++;
        if (mean_l !== 16'h2000 || var_l !== 32'h0) begin
            errors++;
            $display("FAIL t1_l: mean=%h var=%h want 2000 0", mean_l, var_l);
        end
        checks++;
        if (mean_a !== 16'h0 || var_a !== 32'h0) begin
            errors++;
            $display("FAIL t1_a: mean=%h var=%h want 0 0", mean_a, var_a);
        end
        do_ack();
        checks++;
        if ({sv, busy} !== 2'b00 || mean_l !== 16'h2000) begin
            errors++;
            $display("FAIL t1_ack: valid/busy=%b mean_l=%h want 00 2000", {sv, busy}, mean_l);
        end
    endtask

    task automatic test_alternate();
        start_frame();
        send4({4{16'h1000}}, {16'hE000, 16'h2000, 16'hE000, 16'h2000},
              {16'h4000, 16'h0000, 16'h0000, 16'h0000});
        wait_stat();
        checks++;
        if (mean_l !== 16'h1000 || var_l !== 32'h0) begin
            errors++;
            $display("FAIL t2_l: mean=%h var=%h want 1000 0", mean_l, var_l);
        end
        checks++;
        if (mean_a !== 16'h0000 || var_a !== 32'h0400_0000) begin
            errors++;
            $display("FAIL t2_a: mean=%h var=%h want 0000 04000000", mean_a, var_a);
        end
        checks++;
        if (mean_b !== 16'h1000 || var_b !== 32'h0300_0000) begin
            errors++;
            $display("FAIL t2_b: mean=%h var=%h want 1000 03000000", mean_b, var_b);
        end
        do_ack();
    endtask

    task automatic test_floor_clamp();
        start_frame();
        send4(64'h0, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 64'h0);
        wait_stat();
        checks++;
        if (mean_a !== 16'hFFFF || var_a !== 32'h0) begin
            errors++;
            $display("FAIL t3_a: mean=%h var=%h want ffff 0", mean_a, var_a);
        end
        do_ack();
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        int beats;
        int n;
        pat = 16'b1101_0110_0010_1001;
        beats = 0;
        n = 0;
        start_frame();
        while (beats < 4 && n < 40) begin
            valid = pat[n % 16];
            start = (n == 3);
            l = valid ? 16'h2000 : 16'h7FFF;
            a = valid ? 16'h0000 : 16'h7FFF;
            b = valid ? 16'h0000 : 16'h7FFF;
            if (valid && ready) beats++;
            step();
            n++;
        end
        valid = 1'b0;
        start = 1'b0;
        checks++;
        if ({ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL t4_beats: ready/busy=%b after 4 beats want 01", {ready, busy});
        end
        wait_stat();
        checks++;
        if (mean_l !== 16'h2000 || var_l !== 32'h0 || mean_a !== 16'h0 || var_b !== 32'h0) begin
            errors++;
            $display("FAIL t4_stats: ml=%h vl=%h ma=%h vb=%h want 2000 0 0 0", mean_l, var_l, mean_a, var_b);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (sv !== 1'b1 || mean_l !== 16'h2000 || var_l !== 32'h0) begin
                errors++;
                $display("FAIL t4_hold: cycle %0d valid=%b ml=%h vl=%h want 1 2000 0", c, sv, mean_l, var_l);
            end
        end
        ack = 1'b1;
        start = 1'b1;
        step();
        ack = 1'b0;
        start = 1'b0;
        checks++;
        if ({sv, busy} !== 2'b00) begin
            errors++;
            $display("FAIL t4_ack: valid/busy=%b want 00", {sv, busy});
        end
        step();
        checks++;
        if ({ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL t4_start_dropped: ready/busy=%b want 00", {ready, busy});
        end
    endtask

    task automatic test_reset_in_calc();
        start_frame();
        send4({4{16'h2000}}, {4{16'h2000}}, {4{16'h2000}});
        step();
        step();
        checks++;
        if (busy !== 1'b1 || sv !== 1'b0) begin
            errors++;
            $display("FAIL t5_in_calc: busy/valid=%b want 10", {busy, sv});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({ready, busy, sv} !== 3'b000 ||
            {mean_l, mean_a, mean_b, var_l, var_a, var_b} !== '0) begin
            errors++;
            $display("FAIL t5_abort: rbv=%b ml=%h vl=%h ma=%h want 000 0 0 0",
                     {ready, busy, sv}, mean_l, var_l, mean_a);
        end
        start_frame();
        send4({4{16'h0800}}, {4{16'h0800}}, {16'h3000, 16'h3000, 16'h1000, 16'h1000});
        wait_stat();
        checks++;
        if (mean_l !== 16'h0800 || var_l !== 32'h0) begin
            errors++;
            $display("FAIL t5_l: mean=%h var=%h want 0800 0", mean_l, var_l);
        end
        checks++;
        if (mean_b !== 16'h2000 || var_b !== 32'h0100_0000) begin
            errors++;
            $display("FAIL t5_b: mean=%h var=%h want 2000 01000000", mean_b, var_b);
        end
        do_ack();
    endtask

    task automatic test_extremes();
        int beats;
        int n;
        start_frame();
        send4({4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}});
        wait_stat();
        checks++;
        if ({mean_l, mean_a, mean_b} !== {3{16'h8000}} || {var_l, var_a, var_b} !== '0) begin
            errors++;
            $display("FAIL t6_small: m=%h %h %h v=%h %h %h want 8000 x3 0 x3",
                     mean_l, mean_a, mean_b, var_l, var_a, var_b);
        end
        do_ack();

        start16 = 1'b1;
        step();
        start16 = 1'b0;
        p16 = 16'h8000;
        valid16 = 1'b1;
        beats = 0;
        n = 0;
        while (beats < 65536 && n < 70000) begin
            if (ready16) beats++;
            step();
            n++;
        end
        valid16 = 1'b0;
        checks++;
        if (beats != 65536 || ready16 !== 1'b0) begin
            errors++;
            $display("FAIL t6_big_beats: beats=%0d ready=%b want 65536 0", beats, ready16);
        end
        n = 0;
        while (!sv16 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sv16 !== 1'b1) begin
            errors++;
            $display("FAIL t6_big_timeout: o_stat_valid=%b want 1", sv16);
        end
        checks++;
        if ({mean_l16, mean_a16, mean_b16} !== {3{16'h8000}} || {var_l16, var_a16, var_b16} !== '0) begin
            errors++;
            $display("FAIL t6_big: m=%h %h %h v=%h %h %h want 8000 x3 0 x3",
                     mean_l16, mean_a16, mean_b16, var_l16, var_a16, var_b16);
        end
        ack16 = 1'b1;
        step();
        ack16 = 1'b0;
        checks++;
        if ({sv16, busy16} !== 2'b00) begin
            errors++;
            $display("FAIL t6_big_ack: valid/busy=%b want 00", {sv16, busy16});
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; valid = 1'b0; ack = 1'b0;
        l = '0; a = '0; b = '0;
        start16 = 1'b0; valid16 = 1'b0; ack16 = 1'b0; p16 = '0;
        test_reset();
        test_constant();
        test_alternate();
        test_floor_clamp();
        test_backpressure();
        test_reset_in_calc();
        test_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
